// File: rtl/msprite_pkg.sv
// Shared definitions for the multi-sprite engine.
//   - cfg_addr field map and ctrl bit positions
//   - per-sprite state struct
//   - helpers for position clamping and one-step bounce movement
package msprite_pkg;

  localparam logic [4:0] ADDR_X     = 5'd0;
  localparam logic [4:0] ADDR_Y     = 5'd1;
  localparam logic [4:0] ADDR_COLOR = 5'd2;
  localparam logic [4:0] ADDR_CTRL  = 5'd3;
  localparam logic [4:0] ADDR_BMP   = 5'd4;

  localparam int CTRL_DIR_Y = 0;
  localparam int CTRL_DIR_X = 1;
  localparam int CTRL_MOVE  = 2;
  localparam int CTRL_EN    = 3;

  localparam int POS_W       = 8;
  localparam int SHADOW_W    = 16;
  localparam int COLOR_MAX_W = 8;

  typedef struct packed {
    logic [POS_W-1:0]       x;
    logic [POS_W-1:0]       y;
    logic [SHADOW_W-1:0]    x_sh;
    logic [SHADOW_W-1:0]    y_sh;
    logic                   x_pend;
    logic                   y_pend;
    logic [3:0]             ctrl;
    logic [COLOR_MAX_W-1:0] colour;
  } sprite_state_t;

  // Shadows hold the full written value so large writes clamp instead of wrapping.
  function automatic logic [POS_W-1:0] clamp_pos(input logic [SHADOW_W-1:0] v,
                                                 input logic [POS_W-1:0]    lim);
    return (v > {{(SHADOW_W-POS_W){1'b0}}, lim}) ? lim : v[POS_W-1:0];
  endfunction

  // Returns {new_dir, new_pos}. At an edge the direction flips and the sprite holds.
  function automatic logic [POS_W:0] step_axis(input logic [POS_W-1:0] pos,
                                               input logic             dir,
                                               input logic [POS_W-1:0] lim);
    if (dir) begin
      if (pos == '0) return {1'b0, pos};
      else           return {1'b1, pos - 8'd1};
    end else begin
      if (pos >= lim) return {1'b1, pos};
      else            return {1'b0, pos + 8'd1};
    end
  endfunction

endpackage

// File: rtl/msprite_slot.sv
// One sprite: config registers, frame-boundary position commit / movement,
// and the combinational hit test against the current big-pixel counters.
//   clk, rst         clock, async active-high reset
//   i_we, i_addr,    accepted config write targeting this sprite
//   i_data
//   i_next_frame     frame-end strobe (commit / move)
//   i_h, i_v         current column / row
//   o_hit            sprite opaque at (h,v) and enabled (de not applied)
//   o_color          sprite colour
module msprite_slot
  import msprite_pkg::*;
#(
  parameter int SPRITE_WIDTH  = 12,
  parameter int SPRITE_HEIGHT = 12,
  parameter int WIDTH_SMALL   = 100,
  parameter int HEIGHT_SMALL  = 75,
  parameter int COLOR_W       = 6,
  parameter int DATA_W        = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [4:0]         i_addr,
  input  logic [DATA_W-1:0]  i_data,
  input  logic               i_next_frame,
  input  logic [7:0]         i_h,
  input  logic [7:0]         i_v,
  output logic               o_hit,
  output logic [COLOR_W-1:0] o_color
);

  localparam logic [POS_W-1:0] MAX_X   = POS_W'(WIDTH_SMALL - SPRITE_WIDTH);
  localparam logic [POS_W-1:0] MAX_Y   = POS_W'(HEIGHT_SMALL - SPRITE_HEIGHT);
  localparam logic [4:0]       BMP_END = 5'(32'(ADDR_BMP) + SPRITE_HEIGHT);
  localparam int CW = (SPRITE_WIDTH  > 1) ? $clog2(SPRITE_WIDTH)  : 1;
  localparam int RW = (SPRITE_HEIGHT > 1) ? $clog2(SPRITE_HEIGHT) : 1;

  sprite_state_t                             r_st;
  logic [SPRITE_HEIGHT-1:0][SPRITE_WIDTH-1:0] r_bmp;

  logic       w_en, w_move;
  logic [4:0] w_row_addr;
  logic [8:0] w_dx, w_dy;

  assign w_en       = r_st.ctrl[CTRL_EN];
  assign w_move     = r_st.ctrl[CTRL_MOVE];
  assign w_row_addr = i_addr - ADDR_BMP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st  <= '0;
      r_bmp <= '0;
    end else begin
      if (i_we) begin
        if (i_addr == ADDR_X) begin
          r_st.x_sh   <= SHADOW_W'(i_data);
          r_st.x_pend <= 1'b1;
        end else if (i_addr == ADDR_Y) begin
          r_st.y_sh   <= SHADOW_W'(i_data);
          r_st.y_pend <= 1'b1;
        end else if (i_addr == ADDR_COLOR) begin
          r_st.colour <= COLOR_MAX_W'(i_data[COLOR_W-1:0]);
        end else if (i_addr == ADDR_CTRL) begin
          r_st.ctrl <= i_data[3:0];
        end else if (i_addr >= ADDR_BMP && i_addr < BMP_END) begin
          r_bmp[w_row_addr] <= i_data[SPRITE_WIDTH-1:0];
        end
      end
      if (i_next_frame) begin
        // A pending write wins over movement for that axis this frame.
        if (r_st.x_pend) begin
          r_st.x      <= clamp_pos(r_st.x_sh, MAX_X);
          r_st.x_pend <= 1'b0;
        end else if (w_en && w_move) begin
          {r_st.ctrl[CTRL_DIR_X], r_st.x} <= step_axis(r_st.x, r_st.ctrl[CTRL_DIR_X], MAX_X);
        end
        if (r_st.y_pend) begin
          r_st.y      <= clamp_pos(r_st.y_sh, MAX_Y);
          r_st.y_pend <= 1'b0;
        end else if (w_en && w_move) begin
          {r_st.ctrl[CTRL_DIR_Y], r_st.y} <= step_axis(r_st.y, r_st.ctrl[CTRL_DIR_Y], MAX_Y);
        end
      end
    end
  end

  // 9-bit unsigned differences: left/above of the sprite wraps to a large value.
  assign w_dx = {1'b0, i_h} - {1'b0, r_st.x};
  assign w_dy = {1'b0, i_v} - {1'b0, r_st.y};

  assign o_hit = w_en && (w_dx < 9'(SPRITE_WIDTH)) && (w_dy < 9'(SPRITE_HEIGHT))
              && r_bmp[w_dy[RW-1:0]][w_dx[CW-1:0]];
  assign o_color = r_st.colour[COLOR_W-1:0];

endmodule

// File: rtl/multi_sprite_engine.sv
// Multi-sprite overlay: NUM_SPRITES slots, fixed priority (lowest index wins),
// registered pixel output and per-frame collision flags.
//   clk, reset                      clock, async active-high reset
//   next_frame                      frame-end strobe
//   de, counter_h/v_small           display enable and big-pixel position
//   cfg_valid/ready/sprite/addr/data  config write port
//   pixel_on/color/index            registered sprite pixel
//   collision                       per-sprite collision flags of last frame
module multi_sprite_engine
  import msprite_pkg::*;
#(
  parameter int NUM_SPRITES   = 4,
  parameter int SPRITE_WIDTH  = 12,
  parameter int SPRITE_HEIGHT = 12,
  parameter int WIDTH_SMALL   = 100,
  parameter int HEIGHT_SMALL  = 75,
  parameter int COLOR_W       = 6,
  localparam int DATA_W       = (SPRITE_WIDTH > 8) ? SPRITE_WIDTH : 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   next_frame,
  input  logic                   de,
  input  logic [7:0]             counter_h_small,
  input  logic [7:0]             counter_v_small,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [2:0]             cfg_sprite,
  input  logic [4:0]             cfg_addr,
  input  logic [DATA_W-1:0]      cfg_data,
  output logic                   pixel_on,
  output logic [COLOR_W-1:0]     pixel_color,
  output logic [2:0]             pixel_index,
  output logic [NUM_SPRITES-1:0] collision
);

  logic                                w_accept;
  logic [NUM_SPRITES-1:0]              w_hit;
  logic [NUM_SPRITES-1:0][COLOR_W-1:0] w_color;
  logic                                w_any;
  logic [2:0]                          w_sel_idx;
  logic [COLOR_W-1:0]                  w_sel_color;
  logic [NUM_SPRITES-1:0]              w_coll_now;

  logic                   r_pixel_on;
  logic [COLOR_W-1:0]     r_pixel_color;
  logic [2:0]             r_pixel_index;
  logic [NUM_SPRITES-1:0] r_live;
  logic [NUM_SPRITES-1:0] r_collision;

  // No writes on the frame-boundary cycle, so commit never races a shadow update.
  assign cfg_ready = !next_frame && !reset;
  assign w_accept  = cfg_valid && cfg_ready;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
    msprite_slot #(
      .SPRITE_WIDTH (SPRITE_WIDTH),
      .SPRITE_HEIGHT(SPRITE_HEIGHT),
      .WIDTH_SMALL  (WIDTH_SMALL),
      .HEIGHT_SMALL (HEIGHT_SMALL),
      .COLOR_W      (COLOR_W),
      .DATA_W       (DATA_W)
    ) u_slot (
      .clk         (clk),
      .rst         (reset),
      .i_we        (w_accept && (cfg_sprite == 3'(g))),
      .i_addr      (cfg_addr),
      .i_data      (cfg_data),
      .i_next_frame(next_frame),
      .i_h         (counter_h_small),
      .i_v         (counter_v_small),
      .o_hit       (w_hit[g]),
      .o_color     (w_color[g])
    );
  end

  // Scan high to low so the lowest hit index is the last assignment.
  always_comb begin
    w_any       = 1'b0;
    w_sel_idx   = '0;
    w_sel_color = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any       = 1'b1;
        w_sel_idx   = 3'(i);
        w_sel_color = w_color[i];
      end
    end
  end

  // More than one bit set means every hitting sprite is colliding.
  assign w_coll_now = (de && ((w_hit & (w_hit - 1'b1)) != '0)) ? w_hit : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pixel_on    <= 1'b0;
      r_pixel_color <= '0;
      r_pixel_index <= '0;
      r_live        <= '0;
      r_collision   <= '0;
    end else begin
      r_pixel_on    <= de && w_any;
      r_pixel_color <= (de && w_any) ? w_sel_color : '0;
      r_pixel_index <= (de && w_any) ? w_sel_idx   : '0;
      if (next_frame) begin
        r_collision <= r_live | w_coll_now;
        r_live      <= '0;
      end else begin
        r_live <= r_live | w_coll_now;
      end
    end
  end

  assign pixel_on    = r_pixel_on;
  assign pixel_color = r_pixel_color;
  assign pixel_index = r_pixel_index;
  assign collision   = r_collision;

endmodule

// File: tb/tb_multi_sprite_engine.sv
module tb_multi_sprite_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        next_frame = 1'b0;
  logic        de = 1'b0;
  logic [7:0]  counter_h_small = '0;
  logic [7:0]  counter_v_small = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_sprite = '0;
  logic [4:0]  cfg_addr = '0;
  logic [11:0] cfg_data = '0;
  logic        pixel_on;
  logic [5:0]  pixel_color;
  logic [2:0]  pixel_index;
  logic [3:0]  collision;

  int checks = 0;
  int errors = 0;

  multi_sprite_engine dut (
    .clk(clk), .reset(reset), .next_frame(next_frame), .de(de),
    .counter_h_small(counter_h_small), .counter_v_small(counter_v_small),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sprite(cfg_sprite),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pixel_on(pixel_on), .pixel_color(pixel_color), .pixel_index(pixel_index),
    .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input logic [2:0] s, input logic [4:0] a, input logic [11:0] d);
    cfg_valid = 1'b1; cfg_sprite = s; cfg_addr = a; cfg_data = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic nf();
    de = 1'b0; next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
  endtask

  task automatic fill_bmp(input logic [2:0] s, input logic [11:0] d);
    for (int r = 0; r < 12; r++) cfg_wr(s, 5'(4 + r), d);
  endtask

  // Drive one scan position with de high, check the registered pixel next cycle.
  task automatic px(input string tag, input logic [7:0] h, input logic [7:0] v,
                    input logic on, input logic [5:0] col, input logic [2:0] idx);
    counter_h_small = h; counter_v_small = v; de = 1'b1;
    tick();
    chk({tag, ".on"},  32'(pixel_on),    32'(on));
    chk({tag, ".col"}, 32'(pixel_color), 32'(col));
    chk({tag, ".idx"}, 32'(pixel_index), 32'(idx));
    de = 1'b0;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst.ready", 32'(cfg_ready), 32'd0);
    chk("rst.on",    32'(pixel_on),  32'd0);
    chk("rst.coll",  32'(collision), 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("post_rst.ready", 32'(cfg_ready), 32'd1);
    px("post_rst.px00", 8'd0, 8'd0, 1'b0, 6'd0, 3'd0);

    // sprite 0 basic: x/y go through shadows, the rest is immediate
    cfg_wr(3'd0, 5'd0, 12'd10);
    cfg_wr(3'd0, 5'd1, 12'd5);
    cfg_wr(3'd0, 5'd2, 12'b110000);
    fill_bmp(3'd0, 12'hFFF);
    cfg_wr(3'd0, 5'd3, 12'b1000);
    px("s0.pre_commit", 8'd0, 8'd0, 1'b1, 6'b110000, 3'd0);
    nf();
    px("s0.hit",     8'd10, 8'd5,  1'b1, 6'b110000, 3'd0);
    px("s0.right",   8'd22, 8'd5,  1'b0, 6'd0, 3'd0);
    px("s0.corner",  8'd21, 8'd16, 1'b1, 6'b110000, 3'd0);
    px("s0.left",    8'd9,  8'd5,  1'b0, 6'd0, 3'd0);
    px("s0.below",   8'd10, 8'd17, 1'b0, 6'd0, 3'd0);
    px("s0.old_org", 8'd0,  8'd0,  1'b0, 6'd0, 3'd0);
    counter_h_small = 8'd10; counter_v_small = 8'd5; de = 1'b0;
    tick();
    chk("s0.de_low", 32'(pixel_on), 32'd0);

    // overlap of sprites 0 and 2
    cfg_wr(3'd0, 5'd0, 12'd20);
    cfg_wr(3'd0, 5'd1, 12'd20);
    cfg_wr(3'd2, 5'd0, 12'd20);
    cfg_wr(3'd2, 5'd1, 12'd20);
    cfg_wr(3'd2, 5'd2, 12'b001100);
    fill_bmp(3'd2, 12'hFFF);
    cfg_wr(3'd2, 5'd3, 12'b1000);
    nf();
    chk("ovl.coll_before", 32'(collision), 32'd0);
    px("ovl.a", 8'd25, 8'd25, 1'b1, 6'b110000, 3'd0);
    px("ovl.b", 8'd31, 8'd31, 1'b1, 6'b110000, 3'd0);
    px("ovl.c", 8'd32, 8'd25, 1'b0, 6'd0, 3'd0);
    nf();
    chk("ovl.coll", 32'(collision), 32'b0101);
    cfg_wr(3'd0, 5'd4, 12'h000);   // sprite 0 row 0 transparent
    px("ovl.prio_lower", 8'd20, 8'd20, 1'b1, 6'b001100, 3'd2);
    nf();
    chk("ovl.coll_clear", 32'(collision), 32'd0);

    // sprite 1 bounce at the right edge
    cfg_wr(3'd0, 5'd3, 12'd0);
    cfg_wr(3'd2, 5'd3, 12'd0);
    cfg_wr(3'd1, 5'd2, 12'b000011);
    fill_bmp(3'd1, 12'hFFF);
    cfg_wr(3'd1, 5'd0, 12'd88);
    cfg_wr(3'd1, 5'd1, 12'd0);
    cfg_wr(3'd1, 5'd3, 12'b1100);
    nf();
    px("mv1.on",  8'd88, 8'd0, 1'b1, 6'b000011, 3'd1);
    px("mv1.off", 8'd87, 8'd0, 1'b0, 6'd0, 3'd0);
    nf();
    px("mv2.on",  8'd88, 8'd1, 1'b1, 6'b000011, 3'd1);
    px("mv2.off", 8'd87, 8'd1, 1'b0, 6'd0, 3'd0);
    nf();
    px("mv3.on",  8'd87, 8'd2, 1'b1, 6'b000011, 3'd1);
    px("mv3.off", 8'd86, 8'd2, 1'b0, 6'd0, 3'd0);
    px("mv3.rt",  8'd98, 8'd2, 1'b1, 6'b000011, 3'd1);
    px("mv3.rt1", 8'd99, 8'd2, 1'b0, 6'd0, 3'd0);
    cfg_wr(3'd1, 5'd3, 12'b1000);

    // cfg_valid held across next_frame
    cfg_valid = 1'b1; cfg_sprite = 3'd1; cfg_addr = 5'd0; cfg_data = 12'd40;
    next_frame = 1'b1;
    #1;
    chk("hold.ready_nf", 32'(cfg_ready), 32'd0);
    tick();
    next_frame = 1'b0;
    #1;
    chk("hold.ready_after", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    px("hold.not_yet", 8'd87, 8'd2, 1'b1, 6'b000011, 3'd1);
    px("hold.not_new", 8'd40, 8'd2, 1'b0, 6'd0, 3'd0);
    nf();
    px("hold.new", 8'd40, 8'd2, 1'b1, 6'b000011, 3'd1);
    px("hold.old", 8'd87, 8'd2, 1'b0, 6'd0, 3'd0);

    // clamp, plus discarded writes
    cfg_wr(3'd1, 5'd0, 12'd200);
    cfg_wr(3'd1, 5'd16, 12'h000);
    cfg_wr(3'd1, 5'd31, 12'h000);
    cfg_wr(3'd5, 5'd3, 12'b1000);
    nf();
    px("clamp.on",  8'd88, 8'd2, 1'b1, 6'b000011, 3'd1);
    px("clamp.off", 8'd87, 8'd2, 1'b0, 6'd0, 3'd0);

    // reset mid-frame
    counter_h_small = 8'd88; counter_v_small = 8'd2; de = 1'b1;
    tick();
    chk("mid.pre_on", 32'(pixel_on), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid.async_on",  32'(pixel_on),    32'd0);
    chk("mid.async_col", 32'(pixel_color), 32'd0);
    chk("mid.async_idx", 32'(pixel_index), 32'd0);
    chk("mid.ready",     32'(cfg_ready),   32'd0);
    cfg_valid = 1'b1; cfg_sprite = 3'd1; cfg_addr = 5'd3; cfg_data = 12'b1000;
    tick();
    cfg_valid = 1'b0;
    chk("mid.held_on", 32'(pixel_on), 32'd0);
    reset = 1'b0;
    tick();
    chk("mid.release_on", 32'(pixel_on), 32'd0);
    nf();
    chk("mid.coll", 32'(collision), 32'd0);
    px("mid.px00", 8'd0, 8'd0, 1'b0, 6'd0, 3'd0);
    px("mid.px88", 8'd88, 8'd2, 1'b0, 6'd0, 3'd0);
    cfg_wr(3'd0, 5'd4, 12'h001);
    cfg_wr(3'd0, 5'd3, 12'b1000);
    px("recfg.on",  8'd0, 8'd0, 1'b1, 6'd0, 3'd0);
    px("recfg.off", 8'd1, 8'd0, 1'b0, 6'd0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
